// File: rtl/multdiv_issue.sv
// Issue/stall controller between the execute stage and the iterative mult/div unit.
// Optional stall-cycle performance counter is enabled by defining MULTDIV_PERF_EN.
module multdiv_issue #(
  parameter int WIDTH          = 32,
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             issue_valid,
  input  logic             issue_is_div,
  input  logic [WIDTH-1:0] issue_opA,
  input  logic [WIDTH-1:0] issue_opB,
  input  logic [RD_W-1:0]  issue_rd,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  output logic             stall,
  output logic             wb_valid,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_exception,
  output logic [31:0]      perf_stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [RD_W-1:0]  rd_q;
  logic             is_div_q;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      rd_q          <= '0;
      is_div_q      <= 1'b0;
      data_operandA <= '0;
      data_operandB <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exception  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      wb_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (issue_valid) begin
            data_operandA <= issue_opA;
            data_operandB <= issue_opB;
            rd_q          <= issue_rd;
            is_div_q      <= issue_is_div;
            state         <= S_START;
          end
        end
        S_START: begin
          // Any resultRDY seen here belongs to the previous operation.
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (data_resultRDY) begin
            wb_data      <= data_result;
            wb_exception <= data_exception;
            wb_rd        <= rd_q;
            wb_valid     <= 1'b1;
            state        <= S_DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            wb_data      <= '0;
            wb_exception <= 1'b1;
            wb_rd        <= rd_q;
            wb_valid     <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Start pulses decode directly from registered state, so they are glitch-free and exclusive.
  assign ctrl_DIV  = (state == S_START) &&  is_div_q;
  assign ctrl_MULT = (state == S_START) && !is_div_q;

  // Gated by reset so an in-flight stall drops the instant reset is asserted.
  assign stall = !ctrl_reset &&
                 ((state == S_IDLE)  ? issue_valid :
                  (state == S_START) || (state == S_WAIT));

`ifdef MULTDIV_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      perf_q <= '0;
    end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed self-checking bench for multdiv_issue: reset, mult, div, timeout,
// exception with back-to-back issue, and reset in the middle of an operation.
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_is_div = 1'b0;
  logic [31:0] issue_opA = '0;
  logic [31:0] issue_opB = '0;
  logic [4:0]  issue_rd = '0;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result = '0;
  logic        data_exception = 1'b0;
  logic        data_resultRDY = 1'b0;
  logic        stall, wb_valid, wb_exception;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, perf_stall_cycles;

  int checks = 0;
  int errors = 0;

  // Per-operation measurements gathered by run_op.
  int          m_stall, m_mult, m_div, m_wbv, m_done_c, m_pulse_c;
  logic [31:0] m_wb_data, m_opa, m_opb;
  logic [4:0]  m_wb_rd;
  logic        m_wb_exc;

  multdiv_issue dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one complete operation, cycle 0 being the IDLE issue cycle.
  // rdy_k = WAIT cycle (1-based) that raises RDY, 0 = never. Returns in the DONE cycle.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy_k, input logic [31:0] res,
                        input bit exc, input bit rdy_in_start);
    m_stall = 0; m_mult = 0; m_div = 0; m_wbv = 0; m_done_c = -1; m_pulse_c = -1;
    m_wb_data = '0; m_opa = '0; m_opb = '0; m_wb_rd = '0; m_wb_exc = 1'b0;
    for (int c = 0; c < 100; c++) begin
      issue_valid    = (c == 0);
      issue_is_div   = is_div;
      issue_opA      = (c == 0) ? a : ~a;
      issue_opB      = (c == 0) ? b : ~b;
      issue_rd       = (c == 0) ? rd : ~rd;
      data_resultRDY = (rdy_k > 0 && c == rdy_k + 1) || (rdy_in_start && c == 1);
      data_result    = (rdy_k > 0 && c == rdy_k + 1) ? res : 32'hDEAD_BEEF;
      data_exception = (rdy_k > 0 && c == rdy_k + 1) ? exc : 1'b0;
      #1;
      if (stall) m_stall++;
      if (ctrl_MULT) begin m_mult++; m_pulse_c = c; end
      if (ctrl_DIV)  begin m_div++;  m_pulse_c = c; end
      if (c == 1) begin m_opa = data_operandA; m_opb = data_operandB; end
      if (wb_valid) begin
        m_wbv++; m_done_c = c;
        m_wb_data = wb_data; m_wb_rd = wb_rd; m_wb_exc = wb_exception;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic idle_cycle();
    issue_valid = 1'b0; data_resultRDY = 1'b0; data_exception = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #3 ctrl_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'($urandom); issue_is_div = 1'($urandom);
      issue_opA = $urandom; issue_opB = $urandom; issue_rd = 5'($urandom);
      data_result = $urandom; data_resultRDY = 1'($urandom); data_exception = 1'($urandom);
      #1;
      checks++;
      if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got %b required 00000",
                 {ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception});
      end
      checks++;
      if ({data_operandA, data_operandB, wb_data, wb_rd, perf_stall_cycles} !== '0) begin
        errors++;
        $display("FAIL reset_data: opA %h opB %h wb_data %h wb_rd %h perf %0d required all 0",
                 data_operandA, data_operandB, wb_data, wb_rd, perf_stall_cycles);
      end
      @(posedge clock); #1;
    end
    issue_valid = 1'b0; issue_is_div = 1'b0; issue_opA = '0; issue_opB = '0; issue_rd = '0;
    data_resultRDY = 1'b0; data_exception = 1'b0; data_result = '0;
    ctrl_reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, perf_stall_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got mult %b div %b stall %b wbv %b perf %0d required 0",
               ctrl_MULT, ctrl_DIV, stall, wb_valid, perf_stall_cycles);
    end
  endtask

  task automatic test_div();
    run_op(1'b1, 32'd100, 32'd7, 5'd9, 33, 32'd14, 1'b0, 1'b0);
    checks++; if (m_div !== 1) begin errors++; $display("FAIL div_pulse_count: got %0d required 1", m_div); end
    checks++; if (m_mult !== 0) begin errors++; $display("FAIL div_mult_pulse: got %0d required 0", m_mult); end
    checks++; if (m_pulse_c !== 1) begin errors++; $display("FAIL div_pulse_cycle: got %0d required 1", m_pulse_c); end
    checks++; if (m_opa !== 32'd100 || m_opb !== 32'd7) begin
      errors++; $display("FAIL div_operands: got %0d/%0d required 100/7", m_opa, m_opb); end
    checks++; if (m_stall !== 35) begin errors++; $display("FAIL div_stall: got %0d required 35", m_stall); end
    checks++; if (m_done_c !== 35) begin errors++; $display("FAIL div_done_cycle: got %0d required 35", m_done_c); end
    checks++; if (m_wb_rd !== 5'd9 || m_wb_data !== 32'd14 || m_wb_exc !== 1'b0) begin
      errors++; $display("FAIL div_wb: got rd %0d data %0d exc %b required 9 14 0", m_wb_rd, m_wb_data, m_wb_exc); end
    idle_cycle();
    checks++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL div_after: got wbv %b stall %b required 0 0", wb_valid, stall); end
    checks++; if (wb_data !== 32'd14 || data_operandA !== 32'd100) begin
      errors++; $display("FAIL div_hold: got wb_data %0d opA %0d required 14 100", wb_data, data_operandA); end
`ifdef MULTDIV_PERF_EN
    checks++; if (perf_stall_cycles !== 32'd35) begin
      errors++; $display("FAIL perf_after_div: got %0d required 35", perf_stall_cycles); end
`else
    checks++; if (perf_stall_cycles !== 32'd0) begin
      errors++; $display("FAIL perf_tied: got %0d required 0", perf_stall_cycles); end
`endif
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd6, 32'd7, 5'd3, 2, 32'd42, 1'b0, 1'b0);
    checks++; if (m_mult !== 1 || m_div !== 0) begin
      errors++; $display("FAIL mult_pulses: got mult %0d div %0d required 1 0", m_mult, m_div); end
    checks++; if (m_stall !== 4) begin errors++; $display("FAIL mult_stall: got %0d required 4", m_stall); end
    checks++; if (m_done_c !== 4 || m_wb_data !== 32'd42 || m_wb_rd !== 5'd3 || m_wb_exc !== 1'b0) begin
      errors++; $display("FAIL mult_wb: got cyc %0d data %0d rd %0d exc %b required 4 42 3 0",
                         m_done_c, m_wb_data, m_wb_rd, m_wb_exc); end
    idle_cycle();
  endtask

  task automatic test_timeout();
    run_op(1'b1, 32'd50, 32'd3, 5'd17, 0, 32'd0, 1'b0, 1'b1);
    checks++; if (m_done_c !== 42) begin errors++; $display("FAIL timeout_cycle: got %0d required 42", m_done_c); end
    checks++; if (m_stall !== 42) begin errors++; $display("FAIL timeout_stall: got %0d required 42", m_stall); end
    checks++; if (m_wb_data !== 32'd0 || m_wb_exc !== 1'b1 || m_wb_rd !== 5'd17) begin
      errors++; $display("FAIL timeout_wb: got data %h exc %b rd %0d required 0 1 17", m_wb_data, m_wb_exc, m_wb_rd); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 32'd5, 32'd0, 5'd12, 33, 32'd0, 1'b1, 1'b0);
    checks++; if (m_wbv !== 1 || m_done_c !== 35 || m_wb_exc !== 1'b1 || m_wb_data !== 32'd0) begin
      errors++; $display("FAIL divzero_wb: got wbv %0d cyc %0d exc %b data %h required 1 35 1 0",
                         m_wbv, m_done_c, m_wb_exc, m_wb_data); end
    // New instruction presented while still in DONE.
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_opA = 32'd11; issue_opB = 32'd13; issue_rd = 5'd4;
    data_resultRDY = 1'b0; data_exception = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL done_stall: got %b required 0", stall); end
    @(posedge clock); #1;
    checks++; if (ctrl_MULT !== 1'b0 || stall !== 1'b1 || data_operandA !== 32'd5) begin
      errors++; $display("FAIL b2b_idle: got mult %b stall %b opA %0d required 0 1 5", ctrl_MULT, stall, data_operandA); end
    @(posedge clock); #1;
    issue_valid = 1'b0;
    checks++; if (ctrl_MULT !== 1'b1 || ctrl_DIV !== 1'b0 || data_operandA !== 32'd11) begin
      errors++; $display("FAIL b2b_start: got mult %b div %b opA %0d required 1 0 11", ctrl_MULT, ctrl_DIV, data_operandA); end
    @(posedge clock); #1;
    data_resultRDY = 1'b1; data_result = 32'h55;
    @(posedge clock); #1;
    data_resultRDY = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd4) begin
      errors++; $display("FAIL b2b_wb: got wbv %b data %h rd %0d required 1 55 4", wb_valid, wb_data, wb_rd); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int wbv_seen, stall_seen;
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_opA = 32'd77; issue_opB = 32'd8; issue_rd = 5'd21;
    data_resultRDY = 1'b0;
    @(posedge clock); #1;
    issue_valid = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_wait_stall: got %b required 1", stall); end
    #2 ctrl_reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || wb_valid !== 1'b0 || data_operandA !== 32'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL mid_reset: got stall %b wbv %b opA %0d wb_data %h required 0 0 0 0",
                         stall, wb_valid, data_operandA, wb_data); end
    checks++; if (perf_stall_cycles !== 32'd0) begin
      errors++; $display("FAIL mid_reset_perf: got %0d required 0", perf_stall_cycles); end
    #1 ctrl_reset = 1'b0;
    @(posedge clock); #1;
    data_resultRDY = 1'b1; data_result = 32'h99;
    wbv_seen = 0; stall_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (wb_valid) wbv_seen++;
      if (stall) stall_seen++;
      @(posedge clock); #1;
      data_resultRDY = 1'b0;
    end
    checks++; if (wbv_seen !== 0 || stall_seen !== 0) begin
      errors++; $display("FAIL mid_rdy_ignored: got wbv %0d stall %0d required 0 0", wbv_seen, stall_seen); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_mult();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
